// File: rtl/xbar_cfg_pkg.sv
// Shared constants and FSM state type for the crossbar configuration loader.
// Default sizing: 30 inputs, 36 outputs, 5-bit selects, loaded as 8-bit words.
package xbar_cfg_pkg;

  localparam int NUM_IN    = 30;
  localparam int NUM_OUT   = 36;
  localparam int SEL_W     = 5;
  localparam int WORD_W    = 8;
  localparam int CFG_W     = NUM_OUT * SEL_W;
  localparam int NUM_WORDS = (CFG_W + WORD_W - 1) / WORD_W;
  localparam int IDX_W     = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_COMMIT
  } state_t;

endpackage

// File: rtl/xbar_cfg_checker.sv
// Select range scanner: walks one output select per cycle while enabled and
// captures the first select that names a non-existent crossbar input.
module xbar_cfg_checker
  import xbar_cfg_pkg::*;
#(
  parameter int NUM_IN  = xbar_cfg_pkg::NUM_IN,
  parameter int NUM_OUT = xbar_cfg_pkg::NUM_OUT,
  parameter int SEL_W   = xbar_cfg_pkg::SEL_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en_i,
  input  logic [NUM_OUT*SEL_W-1:0] cfg_i,
  output logic                     bad_o,
  output logic                     last_o,
  output logic                     err_o,
  output logic [IDX_W-1:0]         err_idx_o
);

  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] err_idx_q;
  logic             err_q;
  logic [SEL_W-1:0] sel;

  assign sel       = cfg_i[SEL_W*int'(idx_q) +: SEL_W];
  assign bad_o     = en_i && (int'(sel) >= NUM_IN);
  assign last_o    = en_i && (idx_q == IDX_W'(NUM_OUT - 1));
  assign err_o     = err_q;
  assign err_idx_o = err_idx_q;

  // Index parks at 0 whenever the scan is not running, so every scan starts fresh.
  always_ff @(posedge clk) begin
    if (!reset) begin
      idx_q     <= '0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
    end else begin
      err_q <= bad_o;
      if (bad_o) err_idx_q <= idx_q;
      idx_q <= (en_i && !bad_o && !last_o) ? idx_q + 1'b1 : '0;
    end
  end

endmodule

// File: rtl/xbar_cfg_loader.sv
// Crossbar configuration loader: streams select words into a shadow register and
// commits them atomically. Define XBAR_CFG_RANGE_CHECK_EN to add select range checking.
module xbar_cfg_loader
  import xbar_cfg_pkg::*;
#(
  parameter int NUM_IN  = xbar_cfg_pkg::NUM_IN,
  parameter int NUM_OUT = xbar_cfg_pkg::NUM_OUT,
  parameter int SEL_W   = xbar_cfg_pkg::SEL_W,
  parameter int WORD_W  = xbar_cfg_pkg::WORD_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     io_start,
  input  logic                     io_cfg_valid,
  output logic                     io_cfg_ready,
  input  logic [WORD_W-1:0]        io_cfg_data,
  output logic [NUM_OUT*SEL_W-1:0] io_mux_configs,
  output logic                     io_busy,
  output logic                     io_done,
  output logic                     io_err,
  output logic [IDX_W-1:0]         io_err_idx
);

  // state     | meaning
  // ST_IDLE   | waiting for io_start, outputs hold last committed selects
  // ST_LOAD   | accepting config words into the shadow register
  // ST_CHECK  | scanning shadow selects for out-of-range inputs
  // ST_COMMIT | copying shadow to io_mux_configs, pulsing io_done

  localparam int CFG_BITS = NUM_OUT * SEL_W;
  localparam int N_WORDS  = (CFG_BITS + WORD_W - 1) / WORD_W;
  localparam int CNT_W    = $clog2(N_WORDS);

`ifdef XBAR_CFG_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CFG_BITS-1:0] shadow_q;
  logic [CFG_BITS-1:0] shadow_d;
  logic [CFG_BITS-1:0] mux_q;
  logic                done_q;
  logic                accept;
  logic                last_word;
  logic                chk_bad;
  logic                chk_last;

  // A restart request takes priority over a word offered in the same cycle.
  assign io_cfg_ready   = (state_q == ST_LOAD) && !io_start;
  assign accept         = io_cfg_ready && io_cfg_valid;
  assign last_word      = (cnt_q == CNT_W'(N_WORDS - 1));
  assign io_busy        = (state_q != ST_IDLE);
  assign io_mux_configs = mux_q;
  assign io_done        = done_q;

  // The final word only partly overlaps the select field; its upper bits are dropped.
  always_comb begin
    shadow_d = shadow_q;
    if (accept) begin
      for (int b = 0; b < WORD_W; b++) begin
        if (WORD_W * int'(cnt_q) + b < CFG_BITS)
          shadow_d[WORD_W * int'(cnt_q) + b] = io_cfg_data[b];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) shadow_q <= '0;
    else        shadow_q <= shadow_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mux_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (io_start) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
          end
        end
        ST_LOAD: begin
          if (io_start) begin
            cnt_q <= '0;
          end else if (accept) begin
            if (last_word) begin
              cnt_q   <= '0;
              state_q <= RANGE_CHECK ? ST_CHECK : ST_COMMIT;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_CHECK: begin
          if (io_start) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
          end else if (chk_bad) begin
            state_q <= ST_IDLE;
          end else if (chk_last) begin
            state_q <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          mux_q   <= shadow_q;
          done_q  <= 1'b1;
          cnt_q   <= '0;
          state_q <= io_start ? ST_LOAD : ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef XBAR_CFG_RANGE_CHECK_EN
  xbar_cfg_checker #(
    .NUM_IN  (NUM_IN),
    .NUM_OUT (NUM_OUT),
    .SEL_W   (SEL_W)
  ) u_checker (
    .clk       (clk),
    .reset     (reset),
    .en_i      ((state_q == ST_CHECK) && !io_start),
    .cfg_i     (shadow_q),
    .bad_o     (chk_bad),
    .last_o    (chk_last),
    .err_o     (io_err),
    .err_idx_o (io_err_idx)
  );
`else
  assign chk_bad    = 1'b0;
  assign chk_last   = 1'b0;
  assign io_err     = 1'b0;
  assign io_err_idx = '0;
`endif

endmodule

// File: tb/tb_xbar_cfg_loader.sv
// Scoreboard bench for xbar_cfg_loader: the driver pushes the expected commit or
// rejection when the last word is accepted; a monitor pops and checks each pulse.
`timescale 1ns/1ps
module tb_xbar_cfg_loader;
  import xbar_cfg_pkg::*;

  localparam int FULL_W = NUM_WORDS * WORD_W;
  localparam int PAD_W  = FULL_W - CFG_W;

  typedef logic [WORD_W-1:0] word_arr_t [NUM_WORDS];
  typedef struct {
    bit             is_err;
    int             idx;
    logic [CFG_W-1:0] cfg;
    longint         cyc;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              io_start = 1'b0;
  logic              io_cfg_valid = 1'b0;
  logic [WORD_W-1:0] io_cfg_data = '0;
  logic              io_cfg_ready;
  logic [CFG_W-1:0]  io_mux_configs;
  logic              io_busy;
  logic              io_done;
  logic              io_err;
  logic [IDX_W-1:0]  io_err_idx;

  int               n_tests = 0;
  int               n_fail  = 0;
  longint           cyc     = 0;
  bit               mon_en  = 1'b0;
  logic [CFG_W-1:0] cur_cfg = '0;
  exp_t             sb_q[$];

  xbar_cfg_loader #(
    .NUM_IN  (NUM_IN),
    .NUM_OUT (NUM_OUT),
    .SEL_W   (SEL_W),
    .WORD_W  (WORD_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .io_start       (io_start),
    .io_cfg_valid   (io_cfg_valid),
    .io_cfg_ready   (io_cfg_ready),
    .io_cfg_data    (io_cfg_data),
    .io_mux_configs (io_mux_configs),
    .io_busy        (io_busy),
    .io_done        (io_done),
    .io_err         (io_err),
    .io_err_idx     (io_err_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [CFG_W-1:0] act, input logic [CFG_W-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference: words concatenate little-endian into one bit vector; selects are
  // consecutive SEL_W fields of it. Latency counts from the edge accepting the last word.
  function automatic exp_t model(input word_arr_t w, input longint push_cyc);
    exp_t              e;
    logic [FULL_W-1:0] full;
    int                sel;
    full = '0;
    for (int k = 0; k < NUM_WORDS; k++) full = full | (FULL_W'(w[k]) << (WORD_W * k));
    e.cfg    = full[CFG_W-1:0];
    e.is_err = 1'b0;
    e.idx    = 0;
    e.cyc    = push_cyc + 2;
`ifdef XBAR_CFG_RANGE_CHECK_EN
    e.cyc = push_cyc + 2 + NUM_OUT;
    for (int o = 0; o < NUM_OUT; o++) begin
      sel = int'((e.cfg >> (SEL_W * o)) & CFG_W'((1 << SEL_W) - 1));
      if (sel >= NUM_IN && !e.is_err) begin
        e.is_err = 1'b1;
        e.idx    = o;
        e.cyc    = push_cyc + 2 + o;
      end
    end
`endif
    return e;
  endfunction

  function automatic word_arr_t cfg_to_words(input logic [CFG_W-1:0] c);
    word_arr_t         w;
    logic [FULL_W-1:0] f;
    f = {PAD_W'($urandom), c};
    for (int k = 0; k < NUM_WORDS; k++) w[k] = f[WORD_W*k +: WORD_W];
    return w;
  endfunction

  function automatic logic [CFG_W-1:0] rand_cfg(input bit allow_bad);
    logic [CFG_W-1:0] c;
    int               sel;
    c = '0;
    for (int o = 0; o < NUM_OUT; o++) begin
      sel = int'($urandom_range(0, NUM_IN - 1));
      if (allow_bad && $urandom_range(0, 19) == 0) sel = int'($urandom_range(NUM_IN, (1 << SEL_W) - 1));
      c[SEL_W*o +: SEL_W] = SEL_W'(sel);
    end
    return c;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (io_done || io_err) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_pulse", CFG_W'({io_done, io_err}), '0);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("pulse_err", CFG_W'(io_err), CFG_W'(e.is_err));
            chk("pulse_done", CFG_W'(io_done), CFG_W'(!e.is_err));
            chk("pulse_latency", CFG_W'(cyc), CFG_W'(e.cyc));
            chk("busy_at_pulse", CFG_W'(io_busy), '0);
            if (e.is_err) chk("err_idx", CFG_W'(io_err_idx), CFG_W'(e.idx));
            else          cur_cfg = e.cfg;
          end
        end
        chk("mux_cfg", io_mux_configs, cur_cfg);
      end
    end
  end

  // mode: 0 valid always high, 1 valid toggles, 2 valid random.
  // abort_at > 0: send that many junk words, restart, then send w.
  // rst_at > 0: pulse reset after that many words and stop.
  task automatic run_load(input word_arr_t w, input int mode, input int abort_at,
                          input int rst_at, output int accepts);
    word_arr_t junk;
    int        k;
    int        budget;
    bit        in_junk;
    bit        hs;
    bit        tog;
    k       = 0;
    budget  = 600;
    in_junk = (abort_at > 0);
    tog     = 1'b0;
    accepts = 0;
    for (int i = 0; i < NUM_WORDS; i++) junk[i] = WORD_W'($urandom);
    @(posedge clk); #1;
    io_start     = 1'b1;
    io_cfg_valid = 1'b1;
    io_cfg_data  = w[0];
    @(negedge clk);
    chk("ready_idle_start", CFG_W'(io_cfg_ready), '0);
    @(posedge clk); #1;
    io_start = 1'b0;
    while (k < NUM_WORDS && budget > 0) begin
      budget--;
      if (in_junk && accepts == abort_at) begin
        io_cfg_valid = 1'b0;
        io_start     = 1'b1;
        in_junk      = 1'b0;
        k            = 0;
        accepts      = 0;
        @(posedge clk); #1;
        io_start = 1'b0;
        continue;
      end
      if (rst_at > 0 && accepts == rst_at) begin
        io_cfg_valid = 1'b0;
        reset        = 1'b0;
        @(posedge clk); #1;
        reset   = 1'b1;
        cur_cfg = '0;
        @(negedge clk);
        chk("busy_after_reset", CFG_W'(io_busy), '0);
        chk("ready_after_reset", CFG_W'(io_cfg_ready), '0);
        chk("done_after_reset", CFG_W'(io_done), '0);
        chk("err_after_reset", CFG_W'(io_err), '0);
        return;
      end
      case (mode)
        0:       io_cfg_valid = 1'b1;
        1:       io_cfg_valid = tog;
        default: io_cfg_valid = 1'($urandom_range(0, 1));
      endcase
      tog         = !tog;
      io_cfg_data = in_junk ? junk[k] : w[k];
      @(negedge clk);
      hs = io_cfg_ready && io_cfg_valid;
      if (hs && !in_junk && k == NUM_WORDS - 1) sb_q.push_back(model(w, cyc));
      @(posedge clk); #1;
      if (hs) begin
        k++;
        accepts++;
      end
    end
    io_cfg_valid = 1'b0;
    if (k < NUM_WORDS) chk("load_timeout", CFG_W'(k), CFG_W'(NUM_WORDS));
  endtask

  task automatic wait_drain();
    int budget;
    budget = 200;
    while (sb_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (sb_q.size() != 0) begin
      chk("drain_timeout", CFG_W'(sb_q.size()), '0);
      sb_q.delete();
    end
    repeat (2) @(negedge clk);
    chk("busy_after", CFG_W'(io_busy), '0);
    chk("ready_after", CFG_W'(io_cfg_ready), '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog expired");
  end

  initial begin
    word_arr_t        w;
    logic [CFG_W-1:0] c;
    int               acc;

    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mux", io_mux_configs, '0);
    chk("rst_busy", CFG_W'(io_busy), '0);
    chk("rst_ready", CFG_W'(io_cfg_ready), '0);
    chk("rst_done", CFG_W'(io_done), '0);
    chk("rst_err", CFG_W'(io_err), '0);
    chk("rst_err_idx", CFG_W'(io_err_idx), '0);
    reset  = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < NUM_WORDS; i++) w[i] = 8'h21;
    run_load(w, 0, 0, 0, acc);
    chk("full_accepts", CFG_W'(acc), CFG_W'(NUM_WORDS));
    wait_drain();

    run_load(w, 1, 0, 0, acc);
    chk("toggle_accepts", CFG_W'(acc), CFG_W'(NUM_WORDS));
    wait_drain();

    c = '0;
    for (int o = 0; o < NUM_OUT; o++) c[SEL_W*o +: SEL_W] = SEL_W'(o % 4);
    c[SEL_W*7 +: SEL_W]  = 5'd31;
    c[SEL_W*20 +: SEL_W] = 5'd30;
    w = cfg_to_words(c);
    run_load(w, 2, 0, 0, acc);
    wait_drain();

    w = cfg_to_words(rand_cfg(1'b0));
    run_load(w, 0, 10, 0, acc);
    chk("abort_accepts", CFG_W'(acc), CFG_W'(NUM_WORDS));
    wait_drain();

    w = cfg_to_words(rand_cfg(1'b0));
    run_load(w, 0, 0, 15, acc);
    repeat (5) @(negedge clk);
    wait_drain();

    for (int t = 0; t < 12; t++) begin
      w = cfg_to_words(rand_cfg(1'b1));
      run_load(w, 2, 0, 0, acc);
      wait_drain();
    end

    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < NUM_WORDS; i++) w[i] = WORD_W'($urandom);
      run_load(w, t % 3, 0, 0, acc);
      wait_drain();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
